inst_encode_loader: RTL and testbench

- Write-side counterpart to the instruction field extractor.
- Accepts decoded MIPS fields over a valid/ready stream and packs them into 32-bit R/I/J instruction words.
- Writes the words sequentially into instruction memory, starting at a base address.
- Used by the testbench/boot path to build programs in IM. Every word it writes must split back into the same fields when the field extractor reads it.

---
 rtl/inst_encode_loader_pkg.sv | 39 +++
 rtl/inst_encode_loader_pack.sv | 45 ++++
 rtl/inst_encode_loader.sv | 153 +++++++++++++++
 tb/tb_inst_encode_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encode_loader_pkg.sv
// Shared definitions for the instruction encode/load path: format codes,
// instruction field bit positions, loader FSM states and the default IM base.
package inst_encode_loader_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'd0,
      FMT_I   = 2'd1,
      FMT_J   = 2'd2,
      FMT_BAD = 2'd3
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

   // Bit positions identical to those the field extractor slices on read-back.
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SH_HI    = 10;
   localparam int SH_LO    = 6;
   localparam int FN_HI    = 5;
   localparam int FN_LO    = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JIDX_HI  = 25;
   localparam int JIDX_LO  = 0;

endpackage

// File: rtl/inst_encode_loader_pack.sv
// Combinational MIPS field packer: fields + format code -> 32-bit word.
// Fields not belonging to the selected format are ignored.
import inst_encode_loader_pkg::*;

module inst_pack (
   input  logic [1:0]  fmt,
   input  logic [5:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm,
   input  logic [25:0] jidx,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (fmt_e'(fmt))
         FMT_R: begin
            word[OP_HI:OP_LO] = op;
            word[RS_HI:RS_LO] = rs;
            word[RT_HI:RT_LO] = rt;
            word[RD_HI:RD_LO] = rd;
            word[SH_HI:SH_LO] = shamt;
            word[FN_HI:FN_LO] = funct;
         end
         FMT_I: begin
            word[OP_HI:OP_LO]   = op;
            word[RS_HI:RS_LO]   = rs;
            word[RT_HI:RT_LO]   = rt;
            word[IMM_HI:IMM_LO] = imm;
         end
         FMT_J: begin
            word[OP_HI:OP_LO]     = op;
            word[JIDX_HI:JIDX_LO] = jidx;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encode_loader.sv
// Streams decoded field bundles into packed instruction words and writes them
// sequentially into instruction memory from BASE_ADDR, one word per cycle.
import inst_encode_loader_pkg::*;

module inst_encode_loader #(
   parameter int          ADDR_W    = 10,
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [5:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [5:0]        in_funct,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_jidx,
   input  logic              in_last,
   output logic              im_we,
   output logic [31:0]       im_addr,
   output logic [31:0]       im_wdata,
   input  logic              im_stall,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_e            state_reg, state_next;
   logic [ADDR_W:0]   accepted_reg;
   logic [ADDR_W:0]   count_reg;
   logic              err_reg;
   logic              im_we_reg;
   logic [31:0]       im_addr_reg;
   logic [31:0]       im_wdata_reg;
   logic [31:0]       next_addr_reg;

   logic [31:0]       pack_word;
   logic              pack_illegal;
   logic              xfer;
   logic              wr_done;
   logic              session_open;

   inst_pack u_pack (
      .fmt     (in_fmt),
      .op      (in_op),
      .rs      (in_rs),
      .rt      (in_rt),
      .rd      (in_rd),
      .shamt   (in_shamt),
      .funct   (in_funct),
      .imm     (in_imm),
      .jidx    (in_jidx),
      .word    (pack_word),
      .illegal (pack_illegal)
   );

   assign xfer         = in_valid && in_ready;
   assign wr_done      = im_we_reg && !im_stall;
   assign session_open = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start) state_next = ST_RUN;
         ST_RUN:   if (xfer && (in_last || (accepted_reg + ONE_C == DEPTH_C)))
                      state_next = ST_DRAIN;
         ST_DRAIN: if (!im_we_reg) state_next = ST_DONE;
         ST_DONE:  if (start) state_next = ST_RUN;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Ready may rise in the same cycle the held word retires, so there is no bubble.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_reg)
         ST_RUN: begin
            busy     = 1'b1;
            in_ready = (accepted_reg < DEPTH_C) && (!im_we_reg || !im_stall);
         end
         ST_DRAIN: busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         accepted_reg  <= '0;
         count_reg     <= '0;
         err_reg       <= 1'b0;
         im_we_reg     <= 1'b0;
         im_addr_reg   <= BASE_ADDR;
         im_wdata_reg  <= '0;
         next_addr_reg <= BASE_ADDR;
      end else begin
         if (session_open) begin
            accepted_reg  <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            im_addr_reg   <= BASE_ADDR;
            next_addr_reg <= BASE_ADDR;
         end else begin
            if (wr_done && (count_reg != DEPTH_C)) begin
               count_reg <= count_reg + ONE_C;
            end
            if (xfer) begin
               accepted_reg <= accepted_reg + ONE_C;
               // Illegal bundles are consumed without claiming an address slot.
               if (pack_illegal) begin
                  err_reg <= 1'b1;
               end else begin
                  im_addr_reg   <= next_addr_reg;
                  im_wdata_reg  <= pack_word;
                  next_addr_reg <= next_addr_reg + 32'd4;
               end
            end
         end
         if (xfer && !pack_illegal) begin
            im_we_reg <= 1'b1;
         end else if (wr_done) begin
            im_we_reg <= 1'b0;
         end
      end
   end

   assign im_we    = im_we_reg;
   assign im_addr  = im_addr_reg;
   assign im_wdata = im_wdata_reg;
   assign count    = count_reg;
   assign err      = err_reg;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Scoreboard bench: stimulus pushes expected (addr, word) pairs, a monitor pops
// and compares them on every completed IM write.
import inst_encode_loader_pkg::*;

module tb_inst_encode_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready, in_last;
   logic [1:0]  in_fmt;
   logic [5:0]  in_op, in_funct;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_jidx;
   logic        im_we, im_stall, busy, done, err;
   logic [31:0] im_addr, im_wdata;
   logic [10:0] count;

   int n_checks = 0;
   int n_pass   = 0;
   int n_writes = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   inst_encode_loader #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
      .in_jidx(in_jidx), .in_last(in_last),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .im_stall(im_stall),
      .busy(busy), .done(done), .count(count), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_session();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [1:0] fmt, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic last,
                       input logic [31:0] eaddr, input logic [31:0] eword,
                       output int waits);
      in_fmt = fmt; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_funct = fn; in_imm = imm; in_jidx = jidx; in_last = last;
      in_valid = 1'b1;
      if (fmt != FMT_BAD) exp_q.push_back({eaddr, eword});
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready || waits > 50) break;
         waits++;
      end
      if (waits > 50) begin
         n_checks++;
         $display("FAIL send_timeout: in_ready never rose for word %h", eword);
      end else begin
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_im_we"},    {31'd0, im_we},    32'd0);
      chk({tag, "_im_addr"},  im_addr,           32'h0000_3000);
      chk({tag, "_im_wdata"}, im_wdata,          32'd0);
      chk({tag, "_count"},    {21'd0, count},    32'd0);
      chk({tag, "_busy"},     {31'd0, busy},     32'd0);
      chk({tag, "_done"},     {31'd0, done},     32'd0);
      chk({tag, "_err"},      {31'd0, err},      32'd0);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
   endtask

   // Monitor: retire writes against the scoreboard and verify stall holding.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_data;
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_hold_we",   {31'd0, im_we}, 32'd1);
               chk("stall_hold_addr", im_addr,  prev_addr);
               chk("stall_hold_data", im_wdata, prev_data);
            end
            if (im_we && !im_stall) begin
               n_writes++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_write: got %h at %h, expected no write", im_wdata, im_addr);
               end else begin
                  e = exp_q.pop_front();
                  chk("write_addr", im_addr,  e[63:32]);
                  chk("write_data", im_wdata, e[31:0]);
               end
            end
            prev_stall = im_we && im_stall;
            prev_addr  = im_addr;
            prev_data  = im_wdata;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; im_stall = 1'b0;
      in_fmt = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
      in_shamt = '0; in_funct = '0; in_imm = '0; in_jidx = '0; in_last = 1'b0;
      repeat (3) tick();
      check_reset_state("reset");
      reset = 1'b0;

      // R-type addu
      start_session();
      send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hBEEF, 26'h3FFFFFF, 1'b1,
           32'h3000, 32'h00221821, w);
      wait_done();
      chk("r_count", {21'd0, count}, 32'd1);
      chk("r_busy",  {31'd0, busy},  32'd0);

      // I then J back-to-back, junk in unused fields
      start_session();
      send(FMT_I, 6'h0D, 5'd0, 5'd8, 5'h1F, 5'h1F, 6'h3F, 16'h1234, 26'h3FFFFFF, 1'b0,
           32'h3000, 32'h34081234, w);
      chk("lat_we",   {31'd0, im_we}, 32'd1);
      chk("lat_data", im_wdata, 32'h34081234);
      send(FMT_J, 6'h02, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h0000C00, 1'b1,
           32'h3004, 32'h08000C00, w);
      chk("b2b_no_bubble", 32'(w), 32'd0);
      wait_done();
      chk("b2b_count", {21'd0, count}, 32'd2);

      // Stall on second write
      start_session();
      send(FMT_I, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'd0, 1'b0,
           32'h3000, 32'h20220005, w);
      send(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'd0, 26'd0, 1'b0,
           32'h3004, 32'h00853022, w);
      im_stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_ready", {31'd0, in_ready}, 32'd0);
         chk("stall_addr",  im_addr,  32'h3004);
         chk("stall_data",  im_wdata, 32'h00853022);
      end
      tick();
      im_stall = 1'b0;
      send(FMT_R, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'd0, 26'd0, 1'b1,
           32'h3008, 32'h00095100, w);
      wait_done();
      chk("stall_count", {21'd0, count}, 32'd3);

      // Illegal bundle between two words; start during RUN is ignored
      start_session();
      send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0,
           32'h3000, 32'h00221821, w);
      send(FMT_BAD, 6'h3F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0,
           32'h0, 32'h0, w);
      chk("err_set", {31'd0, err}, 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      send(FMT_J, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000C00, 1'b1,
           32'h3004, 32'h08000C00, w);
      wait_done();
      chk("bad_count", {21'd0, count}, 32'd2);
      chk("bad_err",   {31'd0, err},   32'd1);

      // Illegal bundle carrying in_last still ends the session
      start_session();
      chk("err_cleared", {31'd0, err}, 32'd0);
      send(FMT_I, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'd0, 1'b0,
           32'h3000, 32'h20220005, w);
      send(FMT_BAD, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'd0, 1'b1,
           32'h0, 32'h0, w);
      wait_done();
      chk("badlast_count", {21'd0, count}, 32'd1);
      chk("badlast_err",   {31'd0, err},   32'd1);

      // Capacity: DEPTH=4, six offered, none with in_last
      start_session();
      send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0,
           32'h3000, 32'h00221821, w);
      send(FMT_I, 6'h0D, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h1234, 26'd0, 1'b0,
           32'h3004, 32'h34081234, w);
      send(FMT_R, 6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'd0, 26'd0, 1'b0,
           32'h3008, 32'h00853022, w);
      send(FMT_R, 6'h00, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'd0, 26'd0, 1'b0,
           32'h300C, 32'h00095100, w);
      repeat (2) begin
         in_fmt = FMT_J; in_op = 6'h02; in_jidx = 26'h1; in_last = 1'b0;
         in_valid = 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("cap_ready_low", {31'd0, in_ready}, 32'd0);
         end
         tick();
         in_valid = 1'b0;
      end
      wait_done();
      chk("cap_count", {21'd0, count}, 32'd4);

      // Reset with a stalled write pending at 0x3004
      start_session();
      send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0,
           32'h3000, 32'h00221821, w);
      send(FMT_I, 6'h0D, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h1234, 26'd0, 1'b0,
           32'h3004, 32'h34081234, w);
      im_stall = 1'b1;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      im_stall = 1'b0;
      exp_q.delete();
      check_reset_state("midrst");

      // Reset and start together: reset wins
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      tick();
      chk("rst_start_busy", {31'd0, busy}, 32'd0);

      start_session();
      send(FMT_J, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'd0, 26'h0000C00, 1'b1,
           32'h3000, 32'h08000C00, w);
      wait_done();
      chk("restart_count", {21'd0, count}, 32'd1);

      repeat (3) tick();
      chk("queue_empty",  32'(exp_q.size()), 32'd0);
      chk("total_writes", 32'(n_writes), 32'd15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
